// File: rtl/led_disp_pkg.sv
// Shared types and helpers for the LED level display block.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package led_disp_pkg;

    // Display modes as presented on the 2-bit mode input.
    typedef enum logic [1:0] {
        MODE_BAR = 2'd0,
        MODE_DOT = 2'd1,
        MODE_BIN = 2'd2,
        MODE_OFF = 2'd3
    } mode_t;

    // Controller states; IDLE is only ever seen straight out of reset.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_RAMP  = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    // Bits needed to hold a level in 0..n inclusive.
    function automatic int lvl_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running animation prescaler plus blink phase toggler.
// Latency: tick is a 1-cycle pulse while the count sits at PRESC_DIV-1; blink_phase is registered.
// Backpressure: none, runs continuously in every controller state.
module led_tick_gen #(
    parameter int PRESC_DIV   = 50000000,
    parameter int BLINK_TICKS = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick,
    output logic blink_phase
);

    // A divide-by-1 prescaler still needs a 1-bit counter that simply stays at 0.
    localparam int CNT_W = (PRESC_DIV   > 1) ? $clog2(PRESC_DIV)   : 1;
    localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESC_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [BLK_W-1:0] blk_cnt_q;
    logic             phase_q;

    assign tick        = (cnt_q == CNT_LAST);
    assign blink_phase = phase_q;

    // Prescaler: count 0..PRESC_DIV-1 and wrap on the tick cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Blink divider: flip the phase after every BLINK_TICKS ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_q <= '0;
            phase_q   <= 1'b0;
        end else if (tick) begin
            if (blk_cnt_q == BLK_LAST) begin
                blk_cnt_q <= '0;
                phase_q   <= ~phase_q;
            end else begin
                blk_cnt_q <= blk_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_level_display.sv
// Shows a requested level on NUM_LEDS LEDs (bar/dot/binary/off), ramping one LED per tick, blinking on overflow.
// Latency: accepted value affects state/leds on the next edge; ramps advance one step per prescaler tick.
// Backpressure: in_ready is low only while ramping; values offered then are dropped, never queued.
module led_level_display
    import led_disp_pkg::*;
#(
    parameter int IN_W        = 5,
    parameter int NUM_LEDS    = 10,
    parameter int PRESC_DIV   = 50000000,
    parameter int BLINK_TICKS = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_W-1:0]     in_value,
    input  logic [1:0]          mode,
    output logic [NUM_LEDS-1:0] leds,
    output logic                busy,
    output logic                alarm
);

    localparam int LVL_W = lvl_width(NUM_LEDS);
    // Overflow compare is done at the wider of the input and level widths so neither side truncates.
    localparam int CMP_W = (IN_W > LVL_W) ? IN_W : LVL_W;

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(NUM_LEDS);
    localparam logic [CMP_W-1:0] LIMIT    = CMP_W'(NUM_LEDS);

    state_t                state_q;
    state_t                state_d;
    logic [LVL_W-1:0]      cur_q;
    logic [LVL_W-1:0]      cur_d;
    logic [LVL_W-1:0]      tgt_q;
    logic [LVL_W-1:0]      tgt_d;
    logic [LVL_W-1:0]      base_lvl;
    logic [LVL_W-1:0]      step_lvl;
    logic [CMP_W-1:0]      v_ext;
    logic [CMP_W-1:0]      base_ext;
    logic [NUM_LEDS-1:0]   leds_q;
    logic [NUM_LEDS-1:0]   leds_d;
    logic                  tick;
    logic                  blink_phase;
    logic                  accept;
    mode_t                 mode_sel;
    int                    cur_i;

    led_tick_gen #(
        .PRESC_DIV   (PRESC_DIV),
        .BLINK_TICKS (BLINK_TICKS)
    ) u_tick_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .blink_phase (blink_phase)
    );

    // Status outputs follow the registered state directly.
    assign in_ready = (state_q != ST_RAMP);
    assign busy     = (state_q == ST_RAMP);
    assign alarm    = (state_q == ST_ALARM);
    assign accept   = in_valid && in_ready;
    assign v_ext    = CMP_W'(in_value);
    assign mode_sel = mode_t'(mode);
    assign leds     = leds_q;

    // Next-state logic: accept decisions in IDLE/HOLD/ALARM, tick-driven stepping in RAMP.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        tgt_d    = tgt_q;
        // Leaving ALARM starts from a full display; cur_q already holds that, but keep it explicit.
        base_lvl = (state_q == ST_ALARM) ? FULL_LVL : cur_q;
        base_ext = CMP_W'(base_lvl);
        step_lvl = (cur_q < tgt_q) ? (cur_q + 1'b1) : (cur_q - 1'b1);

        case (state_q)
            ST_RAMP: begin
                // The accept edge happens in HOLD/IDLE/ALARM, so a tick on that edge never steps.
                if (tick) begin
                    cur_d = step_lvl;
                    if (step_lvl == tgt_q) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            default: begin
                if (accept) begin
                    if (v_ext > LIMIT) begin
                        state_d = ST_ALARM;
                        cur_d   = FULL_LVL;
                    end else if (v_ext == base_ext) begin
                        state_d = ST_HOLD;
                        cur_d   = base_lvl;
                    end else begin
                        state_d = ST_RAMP;
                        cur_d   = base_lvl;
                        tgt_d   = LVL_W'(v_ext);
                    end
                end
            end
        endcase
    end

    // LED pattern for the values that will be registered on this edge.
    always_comb begin
        leds_d = '0;
        cur_i  = int'(cur_d);
        if (mode_sel != MODE_OFF) begin
            if (state_d == ST_ALARM) begin
                // Uses the phase as it stands before this edge, so the blink lags the divider by one cycle.
                leds_d = {NUM_LEDS{blink_phase}};
            end else begin
                case (mode_sel)
                    MODE_BAR: begin
                        for (int i = 0; i < NUM_LEDS; i++) begin
                            leds_d[i] = (i < cur_i);
                        end
                    end
                    MODE_DOT: begin
                        for (int i = 0; i < NUM_LEDS; i++) begin
                            leds_d[i] = ((i + 1) == cur_i);
                        end
                    end
                    MODE_BIN: begin
                        leds_d = NUM_LEDS'(cur_d);
                    end
                    default: begin
                        leds_d = '0;
                    end
                endcase
            end
        end
    end

    // State, level and target registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
        end
    end

    // Registered LED drive, updated on the same edge as the level and state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leds_q <= '0;
        end else begin
            leds_q <= leds_d;
        end
    end

endmodule

// File: tb/tb_led_level_display.sv
// Bench for led_level_display: reference model pushes expected outputs per edge, monitor pops and compares.
// Latency: n/a.
// Backpressure: n/a.
module tb_led_level_display;

    localparam int PD = 4;
    localparam int BT = 2;
    localparam int NL = 10;
    localparam int IW = 5;

    // Reference-model state names (independent of the RTL encoding).
    localparam int M_IDLE  = 0;
    localparam int M_HOLD  = 1;
    localparam int M_RAMP  = 2;
    localparam int M_ALARM = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_value = '0;
    logic [1:0]    mode = 2'd0;
    logic          in_ready;
    logic [NL-1:0] leds;
    logic          busy;
    logic          alarm;

    typedef struct packed {
        logic [NL-1:0] leds;
        logic          busy;
        logic          alarm;
        logic          rdy;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    int   m_n   = 0;
    int   m_cur = 0;
    int   m_tgt = 0;
    int   m_st  = M_IDLE;

    always #5 clk = ~clk;

    led_level_display #(
        .IN_W        (IW),
        .NUM_LEDS    (NL),
        .PRESC_DIV   (PD),
        .BLINK_TICKS (BT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_value (in_value),
        .mode     (mode),
        .leds     (leds),
        .busy     (busy),
        .alarm    (alarm)
    );

    // Expected LED image from the display rules, using plain arithmetic.
    function automatic logic [NL-1:0] led_pattern(input int st, input int cur, input int md, input int phase);
        longint p;
        p = 0;
        if (md == 3) p = 0;
        else if (st == M_ALARM) p = (phase != 0) ? ((64'd1 << NL) - 1) : 0;
        else if (md == 0) p = (64'd1 << cur) - 1;
        else if (md == 1) p = (cur == 0) ? 0 : (64'd1 << (cur - 1));
        else p = cur;
        return NL'(p);
    endfunction

    // Reference model: one step per clock edge since reset release.
    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        int   v;
        bit   tk;
        int   phase;
        if (!rst_n) begin
            m_n   = 0;
            m_cur = 0;
            m_tgt = 0;
            m_st  = M_IDLE;
            expq.delete();
        end else begin
            m_n   = m_n + 1;
            tk    = ((m_n % PD) == 0);
            phase = ((m_n - 1) / (PD * BT)) % 2;
            if (m_st == M_RAMP) begin
                if (tk) begin
                    m_cur = (m_cur < m_tgt) ? m_cur + 1 : m_cur - 1;
                    if (m_cur == m_tgt) m_st = M_HOLD;
                end
            end else if (in_valid) begin
                v = int'(in_value);
                if (v > NL) begin
                    m_st  = M_ALARM;
                    m_cur = NL;
                end else if (v == m_cur) begin
                    m_st = M_HOLD;
                end else begin
                    m_tgt = v;
                    m_st  = M_RAMP;
                end
            end
            e.leds  = led_pattern(m_st, m_cur, int'(mode), phase);
            e.busy  = (m_st == M_RAMP);
            e.alarm = (m_st == M_ALARM);
            e.rdy   = (m_st != M_RAMP);
            expq.push_back(e);
        end
    end

    // Monitor: compare DUT outputs against the oldest expectation, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && expq.size() > 0) begin
            e = expq.pop_front();
            checks = checks + 1;
            if ({leds, busy, alarm, in_ready} !== e) begin
                errors = errors + 1;
                $display("FAIL outputs t=%0t got leds=%h busy=%b alarm=%b rdy=%b, want leds=%h busy=%b alarm=%b rdy=%b",
                         $time, leds, busy, alarm, in_ready, e.leds, e.busy, e.alarm, e.rdy);
            end
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        checks = checks + 1;
        if (got != want) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_ready();
        int i;
        i = 0;
        while (!in_ready && i < 300) begin
            @(negedge clk);
            i++;
        end
        checks = checks + 1;
        if (!in_ready) begin
            errors = errors + 1;
            $display("FAIL ready_timeout: in_ready=%b after %0d cycles, want 1", in_ready, i);
        end
    endtask

    task automatic send(input int v);
        wait_ready();
        in_valid = 1'b1;
        in_value = IW'(v);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Asynchronous reset between edges, checked immediately, released between edges.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_leds", int'(leds), 0);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_alarm", int'(alarm), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("init_leds", int'(leds), 0);
        chk("init_ready", int'(in_ready), 1);
        chk("init_busy", int'(busy), 0);
        chk("init_alarm", int'(alarm), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Bar ramp up 0 -> 3.
        mode = 2'd0;
        send(3);
        wait_ready();
        // Dot ramp 3 -> 7 then down to 5, with ignored offers during the ramp.
        mode = 2'd1;
        send(7);
        send(5);
        for (int k = 0; k < 3; k++) begin
            idle(2);
            in_valid = 1'b1;
            in_value = IW'(9);
            @(negedge clk);
            in_valid = 1'b0;
        end
        wait_ready();
        // Equal value keeps HOLD.
        send(5);
        idle(4);
        // Overflow, blink, then recover down to 2.
        send(12);
        idle(40);
        send(2);
        wait_ready();
        // Binary mode at 6, then OFF during ALARM.
        mode = 2'd2;
        send(6);
        wait_ready();
        idle(3);
        send(12);
        idle(5);
        mode = 2'd3;
        idle(20);
        mode = 2'd0;
        send(0);
        wait_ready();
        // Reset mid-ramp 0 -> 9.
        send(9);
        idle(6);
        do_reset();

        // Randomized traffic with occasional mode changes and one reset.
        for (int it = 0; it < 3000; it++) begin
            if (it == 1500) do_reset();
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            in_valid = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) in_value = IW'($urandom_range(0, 31));
            else in_value = IW'($urandom_range(0, 13));
            @(negedge clk);
        end
        in_valid = 1'b0;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
